pattern_match_sched: RTL and testbench
======================================

Name: pattern_match_sched

Overview:
- Round-robin scheduler that shares one bit-serial pattern matcher among NUM_CH requesters.
- Each request carries a DATA_W-bit word. The word is serialized MSB-first through a PAT_W-bit sliding window and compared against a configurable pattern; overlapping matches are counted.
- The block returns the match count and the source channel on a valid/ready result port.
- Sits between the per-lane capture logic and the status/interrupt block, replacing one free-running detector per lane.

Parameters:
- NUM_CH, 4, number of requesting channels (≥2).
- DATA_W, 16, bits per request word.
- PAT_W, 4, pattern length in bits (1..DATA_W).
- Derived localparams: CH_W = $clog2(NUM_CH), CNT_W = $clog2(DATA_W+1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_CH  per-channel request valid.
- req_ready  out  NUM_CH  per-channel accept; one-hot or zero.
- req_data  in  NUM_CH*DATA_W  channel i word is bits [i*DATA_W +: DATA_W].
- cfg_pattern  in  PAT_W  pattern; bit PAT_W-1 is compared against the oldest bit in the window.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer accept.
- res_ch  out  CH_W  channel that produced the result.
- res_count  out  CNT_W  number of matches in the word.
- res_hit  out  1  res_count != 0.
- busy  out  1  high in SHIFT and RESULT.

Behaviour:
- Reset (async assert, sync-to-clk deassert is external):
  - State = IDLE, rr_ptr = 0.
  - All outputs 0: req_ready = 0, res_valid = 0, res_ch = 0, res_count = 0, res_hit = 0, busy = 0.
  - Reset mid-SHIFT or mid-RESULT drops the in-flight request. No result is produced for it.
- FSM states and transitions:
  - IDLE:
    - If any req_valid is high, grant the first valid channel at or after rr_ptr, wrapping from NUM_CH-1 to 0.
    - req_ready[grant] = 1 combinationally in the same cycle; that cycle is the handshake.
    - On the edge: latch req_data[grant] into the shift register and cfg_pattern into the pattern register; latch grant into res_ch.
    - Also on the edge: clear window, bit counter and match counter; set rr_ptr = grant+1 (mod NUM_CH); go to SHIFT.
    - If no req_valid is high, stay in IDLE.
  - SHIFT:
    - Exactly DATA_W cycles. Each cycle the shift-register MSB enters window bit 0 and the window shifts left.
    - A match is counted when bits_seen ≥ PAT_W and window == latched pattern, both evaluated after the shift.
    - Overlapping matches count. The window does not carry over between requests.
    - After the DATA_W-th bit, go to RESULT.
  - RESULT:
    - res_valid = 1; res_count and res_hit are stable.
    - Hold until res_ready = 1 on a clock edge, then go to IDLE.
    - No new grant occurs while in SHIFT or RESULT; req_ready = 0 in both.
- Latency: res_valid rises DATA_W+1 clocks after the accept edge. Minimum request-to-request spacing is DATA_W+2 cycles.
- Changes on cfg_pattern after accept have no effect on the current word.
- Max count is DATA_W-PAT_W+1. CNT_W always holds it; there is no wrap.
- Channel deasserting req_valid before its grant: not a protocol error, it is simply skipped. After assertion, the requester must hold req_valid and req_data stable until the handshake.

Optional Feature:
- Macro: PMS_TOTAL_STATS_EN.
- Defined:
  - Adds input stat_clr (1 bit) and output stat_total (32 bits).
  - stat_total accumulates res_count on each result handshake (res_valid & res_ready) and saturates at 32'hFFFF_FFFF.
  - stat_clr zeroes it synchronously; if stat_clr and a handshake coincide, clear wins.
  - stat_total resets to 0.
- Undefined: neither port exists and there is no counter logic.

Decomposition:
- Package pms_pkg:
  - state enum {IDLE, SHIFT, RESULT} as a typedef'd logic [1:0].
  - Function rr_pick(valid, ptr) returning the grant index plus a found flag.
- Sub-module pms_serial_matcher (parameters PAT_W, CNT_W):
  - Inputs: clear, bit_en, bit_in, pattern.
  - Outputs: count.
  - Holds the window, bits_seen and match counter.
- The top holds the FSM, arbiter, data shift register and result port.

Test Plan:
- Overlapping alternating pattern: cfg_pattern = 4'b1010, ch0 req_data = 16'hAAAA → res_ch = 0, res_count = 7, res_hit = 1; res_valid rises 17 cycles after accept.
- All-ones: cfg_pattern = 4'b1111, ch1 data = 16'hFFFF → res_count = 13. Zero data: data = 16'h0000 with pattern 4'b1010 → res_count = 0, res_hit = 0.
- Round-robin: ch0 and ch2 valid continuously, res_ready = 1 → grant order 0, 2, 0, 2; ch1 and ch3 req_ready never asserted.
- Backpressure: res_ready held low 5 cycles in RESULT → res_valid and res_count stable for 5 cycles, no req_ready asserted, ch3 waiting request granted the cycle after the handshake.
- Async reset: rst_n pulsed low at SHIFT cycle 8 → outputs 0 immediately, no res_valid. After release with ch1 and ch2 valid, ch1 is granted first (rr_ptr = 0).
- With PMS_TOTAL_STATS_EN: three 16'hAAAA results with pattern 4'b1010 → stat_total = 21. stat_clr on a handshake edge → stat_total = 0.

Source files
------------

// File: rtl/pms_pkg.sv
// -----------------------------------------------------------------------------
// pms_pkg
// Shared types and helpers for the pattern_match_sched scheduler.
//   state_t   : scheduler FSM encoding (IDLE, SHIFT, RESULT)
//   rr_pick_t : round-robin arbiter result (found flag + grant index)
//   rr_pick() : first valid requester at or after a pointer, wrapping
// -----------------------------------------------------------------------------
package pms_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        RESULT = 2'd2
    } state_t;

    // The arbiter helper works on a fixed-width request vector so it can live
    // in the package; callers zero-extend their request vector into it.
    // Channel counts above RR_MAX_CH are not supported.
    localparam int RR_MAX_CH = 64;
    localparam int RR_IDX_W  = 6;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // Returns the first set bit of valid at or after ptr, wrapping from
    // num_ch-1 back to 0. Offsets are walked from farthest to nearest so the
    // nearest valid channel is the one left in the result.
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX_CH-1:0] valid,
        input int                   ptr,
        input int                   num_ch
    );
        rr_pick_t res;
        int       cand;
        res = '0;
        for (int k = RR_MAX_CH - 1; k >= 0; k--) begin
            if (k < num_ch) begin
                cand = ptr + k;
                if (cand >= num_ch) begin
                    cand = cand - num_ch;
                end
                if (valid[cand[RR_IDX_W-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = cand[RR_IDX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pms_serial_matcher.sv
// -----------------------------------------------------------------------------
// pms_serial_matcher
// Bit-serial sliding-window pattern matcher. Each enabled cycle one bit enters
// window bit 0 and the window shifts left (oldest bit ends up at PAT_W-1).
// Overlapping matches are counted once the window holds PAT_W real bits.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear of window, bits-seen and match counter
//   bit_en     : shift one bit in this cycle
//   bit_in     : incoming serial bit
//   pattern    : pattern to compare against (bit PAT_W-1 = oldest bit)
//   count      : number of matches since the last clear
// -----------------------------------------------------------------------------
module pms_serial_matcher #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             bit_en,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    output logic [CNT_W-1:0] count
);

    localparam int SEEN_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0]  window_reg;
    logic [PAT_W-1:0]  window_next;
    logic [SEEN_W-1:0] seen_reg;
    logic [SEEN_W-1:0] seen_next;
    logic [CNT_W-1:0]  count_reg;
    logic              match;

    // A one-bit window is just the incoming bit; wider windows shift left.
    generate
        if (PAT_W == 1) begin : g_win1
            assign window_next = bit_in;
        end else begin : g_winn
            assign window_next = {window_reg[PAT_W-2:0], bit_in};
        end
    endgenerate

    // bits_seen saturates at PAT_W: once the window is full it stays full.
    always_comb begin
        seen_next = seen_reg;
        if (seen_reg != SEEN_W'(PAT_W)) begin
            seen_next = seen_reg + 1'b1;
        end
        // Both terms use the post-shift view of the window.
        match = (seen_next == SEEN_W'(PAT_W)) && (window_next == pattern);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window_reg <= '0;
            seen_reg   <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            window_reg <= '0;
            seen_reg   <= '0;
            count_reg  <= '0;
        end else if (bit_en) begin
            window_reg <= window_next;
            seen_reg   <= seen_next;
            if (match) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pattern_match_sched.sv
// -----------------------------------------------------------------------------
// pattern_match_sched
// Round-robin scheduler sharing one bit-serial pattern matcher among NUM_CH
// requesters. A granted word is shifted MSB-first through the matcher and the
// overlapping-match count is returned with the source channel.
// Optional feature macro: PMS_TOTAL_STATS_EN (adds stat_clr / stat_total, a
// saturating 32-bit accumulator of res_count over result handshakes).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_valid    : per-channel request valid
//   req_ready    : per-channel accept, one-hot or zero (only in IDLE)
//   req_data     : channel i word at [i*DATA_W +: DATA_W]
//   cfg_pattern  : pattern, sampled at the accept edge
//   res_valid    : result available (RESULT state)
//   res_ready    : result consumer accept
//   res_ch       : channel that produced the result
//   res_count    : number of matches in the word
//   res_hit      : res_count != 0
//   busy         : high in SHIFT and RESULT
//   stat_clr     : (PMS_TOTAL_STATS_EN) synchronous clear of stat_total
//   stat_total   : (PMS_TOTAL_STATS_EN) saturating sum of reported counts
// -----------------------------------------------------------------------------
module pattern_match_sched
    import pms_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 16,
    parameter int PAT_W  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CH-1:0]             req_valid,
    output logic [NUM_CH-1:0]             req_ready,
    input  logic [NUM_CH*DATA_W-1:0]      req_data,
    input  logic [PAT_W-1:0]              cfg_pattern,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [$clog2(NUM_CH)-1:0]     res_ch,
    output logic [$clog2(DATA_W+1)-1:0]   res_count,
    output logic                          res_hit,
    output logic                          busy
`ifdef PMS_TOTAL_STATS_EN
    ,
    input  logic                          stat_clr,
    output logic [31:0]                   stat_total
`endif
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t            state_reg;
    state_t            state_next;
    logic [CH_W-1:0]   rr_ptr_reg;
    logic [DATA_W-1:0] shreg_reg;
    logic [PAT_W-1:0]  pattern_reg;
    logic [CH_W-1:0]   res_ch_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;

    logic [DATA_W-1:0] data_arr [NUM_CH];
    rr_pick_t          pick;
    logic [CH_W-1:0]   grant;
    logic [CH_W-1:0]   grant_inc;
    logic              accept;
    logic              shift_en;
    logic [CNT_W-1:0]  match_count;
    logic              unused_pick_idx;

    // Per-channel view of the flat request data bus.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Arbiter: first valid channel at or after rr_ptr.
    assign pick      = rr_pick(RR_MAX_CH'(req_valid), int'(rr_ptr_reg), NUM_CH);
    assign grant     = pick.idx[CH_W-1:0];
    assign grant_inc = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
    // Upper index bits beyond CH_W are always zero for legal NUM_CH.
    assign unused_pick_idx = ^pick.idx;

    // Next-state and handshake decode.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        shift_en   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick.found) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (bit_cnt_reg == CNT_W'(DATA_W - 1)) begin
                    state_next = RESULT;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            rr_ptr_reg  <= '0;
            shreg_reg   <= '0;
            pattern_reg <= '0;
            res_ch_reg  <= '0;
            bit_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                shreg_reg   <= data_arr[grant];
                pattern_reg <= cfg_pattern;
                res_ch_reg  <= grant;
                bit_cnt_reg <= '0;
                rr_ptr_reg  <= grant_inc;
            end else if (shift_en) begin
                shreg_reg   <= shreg_reg << 1;
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
        end
    end

    // The matcher is cleared on the accept edge so no window state survives
    // from the previous word.
    pms_serial_matcher #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) u_matcher (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .bit_en  (shift_en),
        .bit_in  (shreg_reg[DATA_W-1]),
        .pattern (pattern_reg),
        .count   (match_count)
    );

    // req_ready is decoded from live inputs, so it is also forced low while
    // reset is asserted.
    assign req_ready = (accept && rst_n) ? (NUM_CH'(1) << grant) : '0;
    assign res_valid = (state_reg == RESULT);
    assign res_ch    = res_ch_reg;
    assign res_count = res_valid ? match_count : '0;
    assign res_hit   = (res_count != '0);
    assign busy      = (state_reg != IDLE);

`ifdef PMS_TOTAL_STATS_EN
    logic [31:0] stat_total_reg;
    logic [32:0] stat_sum;

    assign stat_sum = {1'b0, stat_total_reg} + 33'(res_count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_total_reg <= '0;
        end else if (stat_clr) begin
            stat_total_reg <= '0;
        end else if (res_valid && res_ready) begin
            stat_total_reg <= stat_sum[32] ? 32'hFFFF_FFFF : stat_sum[31:0];
        end
    end

    assign stat_total = stat_total_reg;
`endif

endmodule

// File: tb/tb_pattern_match_sched.sv
module tb_pattern_match_sched;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 16;
    localparam int PAT_W  = 4;
    localparam int CH_W   = 2;
    localparam int CNT_W  = 5;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_CH-1:0]        req_valid = '0;
    logic [NUM_CH-1:0]        req_ready;
    logic [NUM_CH*DATA_W-1:0] req_data = '0;
    logic [PAT_W-1:0]         cfg_pattern = '0;
    logic                     res_valid;
    logic                     res_ready = 1'b1;
    logic [CH_W-1:0]          res_ch;
    logic [CNT_W-1:0]         res_count;
    logic                     res_hit;
    logic                     busy;
`ifdef PMS_TOTAL_STATS_EN
    logic                     stat_clr = 1'b0;
    logic [31:0]              stat_total;
`endif

    always #5 clk = ~clk;

    pattern_match_sched #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .PAT_W  (PAT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .cfg_pattern (cfg_pattern),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_ch      (res_ch),
        .res_count   (res_count),
        .res_hit     (res_hit),
        .busy        (busy)
`ifdef PMS_TOTAL_STATS_EN
        ,
        .stat_clr    (stat_clr),
        .stat_total  (stat_total)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int ch;
        int cnt;
    } exp_t;

    exp_t             sbq[$];
    int               grant_log[$];
    int               m_ptr = 0;
    bit               m_busy = 0;
    int               cyc = 0;
    int               acc_cyc = 0;
    logic [NUM_CH-1:0] last_ready = '0;
    int               last_grant_cyc = 0;
    int               last_res_hs_cyc = 0;
    int               first_valid_cyc = 0;
    int               last_ch = -1, last_cnt = -1, last_hit = -1;
    int               hold_cnt = 0, last_hold = 0;
    int               n_results = 0;
    bit               prev_hold = 0, prev_valid = 0;
    int               prev_ch = 0, prev_cnt = 0;
    longint           m_total = 0;

    // Count of PAT_W-bit substrings of d (read MSB-first) equal to p.
    function automatic int ref_count(input logic [DATA_W-1:0] d, input logic [PAT_W-1:0] p);
        int c = 0;
        logic [DATA_W-1:0] sh;
        for (int pos = 0; pos <= DATA_W - PAT_W; pos++) begin
            sh = d >> (DATA_W - PAT_W - pos);
            if (sh[PAT_W-1:0] == p) c++;
        end
        return c;
    endfunction

    function automatic int ref_pick(input logic [NUM_CH-1:0] v, input int ptr);
        for (int k = 0; k < NUM_CH; k++) begin
            if (v[(ptr + k) % NUM_CH]) return (ptr + k) % NUM_CH;
        end
        return -1;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        int                g;
        logic [NUM_CH-1:0] exp_ready;
        bit                exp_valid;
        exp_t              e;
        cyc++;
        if (!rst_n) begin
            m_ptr = 0; m_busy = 0; sbq.delete(); prev_hold = 0; prev_valid = 0;
            m_total = 0; last_ready = '0; hold_cnt = 0;
        end else begin
`ifdef PMS_TOTAL_STATS_EN
            check("stat_total", stat_total, m_total);
`endif
            g = m_busy ? -1 : ref_pick(req_valid, m_ptr);
            exp_ready = (g < 0) ? '0 : (NUM_CH'(1) << g);
            exp_valid = m_busy && ((cyc - acc_cyc) >= DATA_W + 1);
            check("req_ready", req_ready, exp_ready);
            check("busy", busy, m_busy);
            check("res_valid", res_valid, exp_valid);
            last_ready = req_ready;
            if (g >= 0) begin
                e.ch  = g;
                e.cnt = ref_count(req_data[g*DATA_W +: DATA_W], cfg_pattern);
                sbq.push_back(e);
                m_busy = 1; m_ptr = (g + 1) % NUM_CH; acc_cyc = cyc;
                grant_log.push_back(g); last_grant_cyc = cyc;
            end
            if (res_valid) begin
                if (!prev_valid) first_valid_cyc = cyc;
                if (prev_hold) begin
                    check("hold_ch", res_ch, prev_ch);
                    check("hold_count", res_count, prev_cnt);
                end
                if (res_ready) begin
                    if (sbq.size() == 0) begin
                        check("result_expected", 0, 1);
                    end else begin
                        e = sbq.pop_front();
                        check("res_ch", res_ch, e.ch);
                        check("res_count", res_count, e.cnt);
                        check("res_hit", res_hit, e.cnt != 0);
                        last_ch = res_ch; last_cnt = res_count; last_hit = res_hit;
                    end
                    m_busy = 0; last_res_hs_cyc = cyc; n_results++;
                    last_hold = hold_cnt; hold_cnt = 0;
                end else begin
                    hold_cnt++;
                end
                prev_hold = !res_ready; prev_ch = res_ch; prev_cnt = res_count;
            end else begin
                prev_hold = 0;
            end
            prev_valid = res_valid;
`ifdef PMS_TOTAL_STATS_EN
            if (stat_clr) m_total = 0;
            else if (res_valid && res_ready) begin
                m_total = m_total + res_count;
                if (m_total > 64'hFFFF_FFFF) m_total = 64'hFFFF_FFFF;
            end
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int ch, input logic [DATA_W-1:0] d, input logic [PAT_W-1:0] p);
        bit got = 0;
        @(posedge clk); #1;
        req_data[ch*DATA_W +: DATA_W] = d;
        cfg_pattern = p;
        req_valid[ch] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (last_ready[ch]) begin got = 1; break; end
        end
        if (!got) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid[ch] = 1'b0;
        cfg_pattern = ~p;   // later pattern changes must not affect this word
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk); #1;
            if (!m_busy && sbq.size() == 0 && !res_valid) begin done = 1; break; end
        end
        if (!done) check("drain_timeout", 0, 1);
    endtask

    task automatic wait_grants(input int n);
        bit done = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk); #1;
            if (grant_log.size() >= n) begin done = 1; break; end
        end
        if (!done) check("grant_timeout", grant_log.size(), n);
    endtask

    task automatic wait_res_valid();
        bit done = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (res_valid) begin done = 1; break; end
        end
        if (!done) check("res_valid_timeout", 0, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0] nib;
        // reset state, with requests present during reset
        req_valid = 4'b0101;
        @(negedge clk); #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_res_ch", res_ch, 0);
        check("rst_res_count", res_count, 0);
        check("rst_res_hit", res_hit, 0);
        req_valid = '0;
        @(posedge clk); #1 rst_n = 1'b1;

        // alternating pattern with overlap, latency
        send(0, 16'hAAAA, 4'b1010);
        drain();
        check("aaaa_ch", last_ch, 0);
        check("aaaa_count", last_cnt, 7);
        check("aaaa_hit", last_hit, 1);
        check("aaaa_latency", first_valid_cyc - last_grant_cyc, DATA_W + 1);

        // all ones, max count
        send(1, 16'hFFFF, 4'b1111);
        drain();
        check("ones_ch", last_ch, 1);
        check("ones_count", last_cnt, 13);

        // zero data
        send(2, 16'h0000, 4'b1010);
        drain();
        check("zero_count", last_cnt, 0);
        check("zero_hit", last_hit, 0);

        // round robin between ch0 and ch2
        grant_log.delete();
        @(posedge clk); #1;
        req_data[0*DATA_W +: DATA_W] = 16'h1234;
        req_data[2*DATA_W +: DATA_W] = 16'hF0F0;
        cfg_pattern = 4'b0011;
        req_valid = 4'b0101;
        wait_grants(4);
        @(posedge clk); #1 req_valid = '0;
        drain();
        check("rr_g0", grant_log[0], 0);
        check("rr_g1", grant_log[1], 2);
        check("rr_g2", grant_log[2], 0);
        check("rr_g3", grant_log[3], 2);

        // backpressure: 5 held RESULT cycles, ch3 granted right after
        res_ready = 1'b0;
        send(0, 16'h5A5A, 4'b0101);
        req_data[3*DATA_W +: DATA_W] = 16'hCCCC;
        req_valid[3] = 1'b1;
        wait_res_valid();
        repeat (4) @(negedge clk);
        @(posedge clk); #1 res_ready = 1'b1;
        grant_log.delete();
        wait_grants(1);
        @(posedge clk); #1 req_valid[3] = 1'b0;
        check("bp_hold_cycles", last_hold, 5);
        check("bp_next_grant", grant_log[0], 3);
        check("bp_grant_gap", last_grant_cyc - last_res_hs_cyc, 1);
        drain();

        // asynchronous reset during SHIFT cycle 8
        send(1, 16'hBEEF, 4'b1110);
        repeat (7) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_res_valid", res_valid, 0);
        check("arst_res_ch", res_ch, 0);
        check("arst_res_count", res_count, 0);
        check("arst_req_ready", req_ready, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        grant_log.delete();
        req_data[1*DATA_W +: DATA_W] = 16'h0F0F;
        req_data[2*DATA_W +: DATA_W] = 16'h3333;
        req_valid = 4'b0110;
        wait_grants(1);
        @(posedge clk); #1 req_valid[1] = 1'b0;
        check("arst_first_grant", grant_log[0], 1);
        wait_grants(2);
        @(posedge clk); #1 req_valid[2] = 1'b0;
        drain();

`ifdef PMS_TOTAL_STATS_EN
        @(posedge clk); #1 stat_clr = 1'b1;
        @(posedge clk); #1 stat_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(i, 16'hAAAA, 4'b1010);
            drain();
        end
        check("stat_total_21", stat_total, 21);
        res_ready = 1'b0;
        send(3, 16'hAAAA, 4'b1010);
        wait_res_valid();
        @(posedge clk); #1 res_ready = 1'b1; stat_clr = 1'b1;
        @(posedge clk); #1 stat_clr = 1'b0;
        @(negedge clk); #1;
        check("stat_clr_wins", stat_total, 0);
        drain();
`endif

        // randomized traffic with backpressure and changing patterns
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NUM_CH; i++) begin
                if ((req_valid[i] && last_ready[i]) || (!req_valid[i] && $urandom_range(0, 3) == 0)) begin
                    req_valid[i] = (req_valid[i] && last_ready[i]) ? 1'($urandom_range(0, 1)) : 1'b1;
                    nib = 4'($urandom);
                    req_data[i*DATA_W +: DATA_W] = ($urandom_range(0, 2) == 0) ? {4{nib}} : 16'($urandom);
                end
            end
            cfg_pattern = 4'($urandom);
            res_ready = ($urandom_range(0, 2) != 0);
`ifdef PMS_TOTAL_STATS_EN
            stat_clr = ($urandom_range(0, 99) == 0);
`endif
        end
        @(posedge clk); #1;
        req_valid = '0;
        res_ready = 1'b1;
`ifdef PMS_TOTAL_STATS_EN
        stat_clr = 1'b0;
`endif
        drain();
        check("random_progress", n_results > 50, 1);
        check("scoreboard_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
